// File: rtl/kmap_truth_scan.sv
// kmap_truth_scan
// Walks every input vector of an N_IN-input combinational block, holds each
// one for SETTLE cycles, samples the block's single output on the last held
// cycle and builds the full truth table plus a count of its minterms.
//
// Handshake: start is a level sampled on the rising edge and is only accepted
// in IDLE; busy is high for the whole scan; done is a one-cycle pulse in the
// cycle in which truth_table and minterm_cnt hold the finished result.
module kmap_truth_scan #(
   parameter int N_IN   = 4,
   parameter int SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 f_in,
   output logic [N_IN-1:0]      x_out,
   output logic                 busy,
   output logic                 done,
   output logic [2**N_IN-1:0]   truth_table,
   output logic [N_IN:0]        minterm_cnt
);

   // Settle counter only needs to reach SETTLE-1; keep at least one bit.
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [N_IN-1:0] idx;
   logic [CW-1:0]   cnt;
   logic            accept;
   logic            sample_now;
   logic            last_idx;

   // A start only counts while idle; everywhere else it is ignored.
   assign accept     = (state == IDLE) && start;
   // The last held cycle of the current vector is the sampling edge.
   assign sample_now = (state == HOLD) && (cnt == CW'(SETTLE - 1));
   assign last_idx   = (idx == {N_IN{1'b1}});

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: IDLE -> HOLD on start, HOLD -> DONE after the last sample.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (sample_now && last_idx) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Outputs decoded from state; the vector is only driven while holding.
   always_comb begin
      busy  = 1'b0;
      done  = 1'b0;
      x_out = '0;
      case (state)
         HOLD: begin
            busy  = 1'b1;
            x_out = idx;
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
            busy  = 1'b0;
         end
      endcase
   end

   // Vector index and settle counter: advance the vector after each sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx <= '0;
         cnt <= '0;
      end else if (accept) begin
         idx <= '0;
         cnt <= '0;
      end else if (state == HOLD) begin
         if (sample_now) begin
            cnt <= '0;
            if (!last_idx) begin
               idx <= idx + 1'b1;
            end
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   // Result registers: cleared on acceptance, updated only on sampling edges.
   always_ff @(posedge clk) begin
      if (rst) begin
         truth_table <= '0;
         minterm_cnt <= '0;
      end else if (accept) begin
         truth_table <= '0;
         minterm_cnt <= '0;
      end else if (sample_now) begin
         truth_table[idx] <= f_in;
         minterm_cnt      <= minterm_cnt + {{N_IN{1'b0}}, f_in};
      end
   end

endmodule

// File: tb/tb_kmap_truth_scan.sv
// tb_kmap_truth_scan
// Directed bench for kmap_truth_scan: one instance with default settings and
// one with SETTLE=3. Each instance's f_in comes from a small selectable
// function model of x_out; expected tables are hand-computed constants.
module tb_kmap_truth_scan;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_a = 1'b0;
   logic        start_b = 1'b0;
   logic        f_a;
   logic        f_b;
   logic [3:0]  x_a;
   logic [3:0]  x_b;
   logic        busy_a;
   logic        busy_b;
   logic        done_a;
   logic        done_b;
   logic [15:0] tt_a;
   logic [15:0] tt_b;
   logic [4:0]  mc_a;
   logic [4:0]  mc_b;

   int mode_a = 0;
   int mode_b = 0;
   bit sel    = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   logic [3:0]  o_x;
   logic        o_busy;
   logic        o_done;
   logic [15:0] o_tt;
   logic [4:0]  o_mc;

   // Clock generation.
   always #5 clk = ~clk;

   kmap_truth_scan #(.N_IN(4), .SETTLE(1)) dut_a (
      .clk         (clk),
      .rst         (rst),
      .start       (start_a),
      .f_in        (f_a),
      .x_out       (x_a),
      .busy        (busy_a),
      .done        (done_a),
      .truth_table (tt_a),
      .minterm_cnt (mc_a)
   );

   kmap_truth_scan #(.N_IN(4), .SETTLE(3)) dut_b (
      .clk         (clk),
      .rst         (rst),
      .start       (start_b),
      .f_in        (f_b),
      .x_out       (x_b),
      .busy        (busy_b),
      .done        (done_b),
      .truth_table (tt_b),
      .minterm_cnt (mc_b)
   );

   // Function models of the block under evaluation.
   function automatic logic fmodel(input int m, input logic [3:0] x);
      case (m)
         1:       return 1'b1;
         2:       return (x == 4'd5) || (x == 4'd10);
         3:       return x[0];
         4:       return x[1];
         default: return 1'b0;
      endcase
   endfunction

   // Feed each instance's x_out back through its selected model.
   always_comb begin
      f_a = fmodel(mode_a, x_a);
      f_b = fmodel(mode_b, x_b);
   end

   // Observation mux so the scan tasks work on either instance.
   always_comb begin
      o_x    = sel ? x_b    : x_a;
      o_busy = sel ? busy_b : busy_a;
      o_done = sel ? done_b : done_a;
      o_tt   = sel ? tt_b   : tt_a;
      o_mc   = sel ? mc_b   : mc_a;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and sample just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_start(input logic v);
      if (sel) start_b = v;
      else     start_a = v;
   endtask

   // Start a scan and follow it to done, checking vector order and timing.
   task automatic run_scan(input string tag, input int settle, input int inject_at);
      int lat;
      int busy_cyc;
      bit seq_ok;
      bit injected;
      lat      = -1;
      busy_cyc = 0;
      seq_ok   = 1'b1;
      injected = 1'b0;
      drive_start(1'b1);
      tick();
      drive_start(1'b0);
      check({tag, " cleared_tt"}, 32'(o_tt), 32'h0);
      check({tag, " cleared_mc"}, 32'(o_mc), 32'h0);
      for (int k = 0; k < 40 * settle + 40; k++) begin
         drive_start(1'b0);
         if (o_done) begin
            lat = k;
            break;
         end
         if (o_busy) busy_cyc++;
         if (o_x != 4'(k / settle)) seq_ok = 1'b0;
         if (inject_at >= 0 && !injected && o_x == 4'(inject_at)) begin
            injected = 1'b1;
            drive_start(1'b1);
         end
         tick();
      end
      drive_start(1'b0);
      check({tag, " latency"}, 32'(lat), 32'(16 * settle));
      check({tag, " busy_cycles"}, 32'(busy_cyc), 32'(16 * settle));
      check({tag, " vector_order"}, 32'(seq_ok), 32'h1);
   endtask

   // Check the result in the done cycle, then the return to idle.
   task automatic check_result(input string tag, input logic [15:0] exp_tt,
                               input logic [4:0] exp_mc, input bit start_in_done);
      check({tag, " truth_table"}, 32'(o_tt), 32'(exp_tt));
      check({tag, " minterm_cnt"}, 32'(o_mc), 32'(exp_mc));
      check({tag, " done_busy"}, 32'({o_done, o_busy}), 32'h2);
      check({tag, " done_x"}, 32'(o_x), 32'h0);
      if (start_in_done) drive_start(1'b1);
      tick();
      drive_start(1'b0);
      check({tag, " done_pulse_end"}, 32'({o_done, o_busy}), 32'h0);
      check({tag, " held_tt"}, 32'(o_tt), 32'(exp_tt));
   endtask

   initial begin
      int dones;
      int busys;
      bit found;

      // Reset
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      check("rst_a", 32'({x_a, busy_a, done_a, tt_a, mc_a}), 32'h0);
      check("rst_b", 32'({x_b, busy_b, done_b, tt_b, mc_b}), 32'h0);
      tick();
      check("idle_a", 32'({x_a, busy_a, done_a}), 32'h0);

      // T1: minterms 5 and 10
      sel    = 1'b0;
      mode_a = 2;
      #1;
      run_scan("t1", 1, -1);
      check_result("t1", 16'h0420, 5'd2, 1'b0);

      // T2: constant one (count reaches 16 without wrapping), then constant zero
      mode_a = 1;
      run_scan("t2_one", 1, -1);
      check_result("t2_one", 16'hFFFF, 5'd16, 1'b0);
      mode_a = 0;
      run_scan("t2_zero", 1, -1);
      check_result("t2_zero", 16'h0000, 5'd0, 1'b0);

      // T3: SETTLE=3, f = x[0]
      sel    = 1'b1;
      mode_b = 3;
      #1;
      run_scan("t3", 3, -1);
      check_result("t3", 16'hAAAA, 5'd8, 1'b0);
      sel = 1'b0;
      #1;

      // T4: start pulsed at idx 6 and in the done cycle, both ignored
      mode_a = 4;
      run_scan("t4", 1, 6);
      check_result("t4", 16'hCCCC, 5'd8, 1'b1);
      dones = 0;
      busys = 0;
      for (int k = 0; k < 30; k++) begin
         if (done_a) dones++;
         if (busy_a) busys++;
         tick();
      end
      check("t4 no_rescan_busy", 32'(busys), 32'h0);
      check("t4 no_extra_done", 32'(dones), 32'h0);
      check("t4 tt_kept", 32'(tt_a), 32'hCCCC);

      // T5: reset while x_out is 7
      mode_a  = 1;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      found   = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (x_a == 4'd7 && busy_a) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      check("t5 reached_x7", 32'(found), 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5 outputs_zero", 32'({x_a, busy_a, done_a, tt_a, mc_a}), 32'h0);
      dones = 0;
      for (int k = 0; k < 30; k++) begin
         if (done_a) dones++;
         tick();
      end
      check("t5 no_done", 32'(dones), 32'h0);
      mode_a = 2;
      run_scan("t5_rescan", 1, -1);
      check_result("t5_rescan", 16'h0420, 5'd2, 1'b0);

      // T6: back-to-back scans, no stale bits carried over
      mode_a = 1;
      run_scan("t6_first", 1, -1);
      check_result("t6_first", 16'hFFFF, 5'd16, 1'b0);
      mode_a = 2;
      run_scan("t6_second", 1, -1);
      check_result("t6_second", 16'h0420, 5'd2, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
